// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared pipeline constants and the fetch buffer entry layout.
package fetch_buffer_pkg;
    localparam int XLEN = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [XLEN-1:0] NOP = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fb_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: show-ahead instruction FIFO between fetch and decode, cleared by branch redirect.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    fb_entry_t      r_mem [DEPTH];
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic           w_push;
    logic           w_pop;
    fb_entry_t      w_head;

    // in_ready ignores out_ready on purpose: a full buffer never accepts, even alongside a pop.
    assign in_ready  = r_count != FULL;
    assign out_valid = r_count != '0;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_instr = out_valid ? w_head.instr : NOP;
    assign out_pc    = out_valid ? w_head.pc : NOP;
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
        end
    end

    // Storage is not reset; the head is masked to NOP whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of the fetch buffer with DEPTH=4.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        flush;
    logic [2:0]  count;

    int vectors = 0;
    int errs = 0;

    fetch_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid = v; in_pc = pc; in_instr = ins(pc); out_ready = rdy; flush = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // three pushes, no pop; no same-cycle bypass before the first edge
        drive(1'b1, 32'd4, 1'b0, 1'b0);
        #1 check("no_bypass", 32'(out_valid), 32'd0);
        tick();
        check("show_ahead_valid", 32'(out_valid), 32'd1);
        check("show_ahead_pc", out_pc, 32'd4);
        drive(1'b1, 32'd8, 1'b0, 1'b0);  tick();
        drive(1'b1, 32'd12, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("three_count", 32'(count), 32'd3);
        check("three_in_ready", 32'(in_ready), 32'd1);
        check("three_out_pc", out_pc, 32'd4);
        check("three_out_instr", out_instr, ins(32'd4));

        // fill to DEPTH, then an ignored fifth push
        drive(1'b1, 32'd16, 1'b0, 1'b0); tick();
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'd20, 1'b0, 1'b0); tick();
        check("overfill_count", 32'(count), 32'd4);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_pc", out_pc, 32'(4 * i));
            check("drain_instr", out_instr, ins(32'(4 * i)));
            tick();
        end
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_instr", out_instr, 32'h0);
        tick();
        check("pop_empty_count", 32'(count), 32'd0);
        check("pop_empty_in_ready", 32'(in_ready), 32'd1);

        // streaming across pointer wrap
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
            if (k == 0) check("stream_first_invalid", 32'(out_valid), 32'd0);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", out_pc, 32'h100 + 32'(4 * k));
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0); tick();
        check("stream_end_count", 32'(count), 32'd0);

        // full with simultaneous pop: only the pop happens
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0); tick();
        end
        check("full2_count", 32'(count), 32'd4);
        drive(1'b1, 32'h300, 1'b1, 1'b0); tick();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_pc", out_pc, 32'h204);
        check("full_pop_in_ready", 32'(in_ready), 32'd1);

        // flush beats same-cycle push and pop
        drive(1'b1, 32'h999, 1'b1, 1'b1); tick();
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_instr", out_instr, 32'h0);
        check("flush_pc", out_pc, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick();
        check("post_flush_count", 32'(count), 32'd1);
        check("post_flush_pc", out_pc, 32'h40);
        check("post_flush_instr", out_instr, ins(32'h40));

        // asynchronous reset between edges
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("pre_arst_count", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1 check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_instr", out_instr, 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h80, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("post_arst_count", 32'(count), 32'd1);
        check("post_arst_pc", out_pc, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
